// File: rtl/audio_tdm_tx.sv
// Serial audio transmitter: frame FIFO feeding an I2S / TDM (DSP-A) serialiser.
// SCLK, LRCLK and SDA are generated from the system clock and leave the block registered.
module audio_tdm_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 16,
  parameter int CHANNELS   = 2,
  parameter int MODE       = 0,
  parameter int SCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             sample_valid,
  output logic                             sample_ready,
  input  logic [CHANNELS*SAMPLE_W-1:0]     sample_data,
  output logic                             i2s_sclk,
  output logic                             i2s_lrclk,
  output logic                             i2s_sda,
  output logic                             frame_start,
  output logic                             underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int FRAME_BITS = CHANNELS * SLOT_W;
  localparam int DATA_W     = CHANNELS * SAMPLE_W;
  localparam int LAST_CNT   = 2 * SCLK_DIV - 1;
  localparam int CNT_W      = $clog2(2 * SCLK_DIV);
  localparam int P_W        = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

  // DRAIN plays out the period that carries the last bit of the final frame.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 next_state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [P_W-1:0]         p_r;
  logic [FRAME_BITS-1:0]  shift_r;
  logic [DATA_W-1:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [LVL_W-1:0]       level_r;
  logic                   active_s;
  logic                   frame_edge_s;
  logic                   load_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   empty_s;
  logic                   lr_s;
  logic                   cnt_last_s;
  logic                   p_last_s;

  // Left-aligned, MSB-first slots; stream bit 0 sits at the top of the vector.
  function automatic logic [FRAME_BITS-1:0] format_frame(input logic [DATA_W-1:0] data);
    logic [FRAME_BITS-1:0] stream;
    stream = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      stream[FRAME_BITS-1-c*SLOT_W -: SAMPLE_W] = data[c*SAMPLE_W +: SAMPLE_W];
    end
    return stream;
  endfunction

  assign fifo_level   = level_r;
  assign sample_ready = (level_r != LVL_W'(FIFO_DEPTH));

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state logic: enable is only honoured at the start of period 0
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) next_state_s = RUN;
        else        next_state_s = IDLE;
      end
      RUN: begin
        if (frame_edge_s && !enable) next_state_s = DRAIN;
        else                         next_state_s = RUN;
      end
      DRAIN: begin
        if (cnt_last_s) next_state_s = IDLE;
        else            next_state_s = DRAIN;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // per-cycle control decoded from state and counters
  always_comb begin
    active_s     = 1'b0;
    cnt_last_s   = (cnt_r == CNT_W'(LAST_CNT));
    p_last_s     = (p_r == P_W'(FRAME_BITS - 1));
    frame_edge_s = (cnt_r == '0) && (p_r == '0);
    empty_s      = (level_r == '0);
    case (state_r)
      IDLE:        active_s = enable;
      RUN, DRAIN:  active_s = 1'b1;
      default:     active_s = 1'b0;
    endcase
    load_s = frame_edge_s && enable && (state_r != DRAIN);
    pop_s  = load_s && !empty_s;
    push_s = sample_valid && sample_ready;
    if (MODE == 0) begin
      lr_s = (p_r >= P_W'(SLOT_W));
    end else begin
      lr_s = (p_r == '0);
    end
  end

  // clk-within-period and period counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      p_r   <= '0;
    end else if (!active_s || (state_r == DRAIN && cnt_last_s)) begin
      cnt_r <= '0;
      p_r   <= '0;
    end else if (cnt_last_s) begin
      cnt_r <= '0;
      if (p_last_s) p_r <= '0;
      else          p_r <= p_r + 1'b1;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // frame storage; data is not reset, pointers are
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= sample_data;
  end

  // FIFO pointers and occupancy; no bypass, so a pop on empty never sees a same-cycle push
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  // shift register: the old MSB leaves on the same edge the new frame arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= '0;
    end else if (load_s) begin
      shift_r <= empty_s ? '0 : format_frame(mem_r[rd_ptr_r]);
    end else if (!active_s) begin
      shift_r <= '0;
    end else if (cnt_r == '0) begin
      shift_r <= {shift_r[FRAME_BITS-2:0], 1'b0};
    end
  end

  // registered serial outputs and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      i2s_sclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_sda     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= load_s;
      underrun    <= load_s && empty_s;
      if (active_s) begin
        i2s_sclk  <= (cnt_r >= CNT_W'(SCLK_DIV));
        i2s_lrclk <= lr_s;
        if (cnt_r == '0) i2s_sda <= shift_r[FRAME_BITS-1];
      end else begin
        i2s_sclk  <= 1'b0;
        i2s_lrclk <= 1'b0;
        i2s_sda   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_tdm_tx.sv
// Scoreboard bench: an I2S instance and a 4-slot TDM instance; expected bits per SCLK rise
// and expected frame_start/underrun events are queued by the stimulus and popped by monitors.
module tb_audio_tdm_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_a, valid_a, ready_a, sclk_a, lr_a, sda_a, fs_a, ur_a;
  logic [31:0] data_a;
  logic [2:0]  lvl_a;
  logic        en_b, valid_b, ready_b, sclk_b, lr_b, sda_b, fs_b, ur_b;
  logic [63:0] data_b;
  logic [2:0]  lvl_b;

  audio_tdm_tx dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .sample_valid(valid_a), .sample_ready(ready_a),
    .sample_data(data_a), .i2s_sclk(sclk_a), .i2s_lrclk(lr_a), .i2s_sda(sda_a),
    .frame_start(fs_a), .underrun(ur_a), .fifo_level(lvl_a)
  );

  audio_tdm_tx #(.SAMPLE_W(16), .SLOT_W(16), .CHANNELS(4), .MODE(1), .SCLK_DIV(4), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .sample_valid(valid_b), .sample_ready(ready_b),
    .sample_data(data_b), .i2s_sclk(sclk_b), .i2s_lrclk(lr_b), .i2s_sda(sda_b),
    .frame_start(fs_b), .underrun(ur_b), .fifo_level(lvl_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fs_a = 0;
  int last_fs_b = 0;
  logic mon_a_on = 1'b0;
  logic sclk_a_d = 1'b0;
  logic sclk_b_d = 1'b0;
  logic [1:0] e_a, e_b, f_a, f_b;
  logic [1:0] bit_a_q[$];   // {lrclk, sda} per SCLK rise
  logic [1:0] bit_b_q[$];
  logic [1:0] fs_a_q[$];    // {check_gap, underrun} per frame_start
  logic [1:0] fs_b_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // stream is the hand-formatted frame, bit 0 (left MSB) at [31]
  task automatic exp_a_frame(input logic [31:0] stream, input logic prev);
    logic lr, b;
    for (int p = 0; p < 32; p++) begin
      lr = (p >= 16);
      b  = (p == 0) ? prev : stream[32-p];
      bit_a_q.push_back({lr, b});
    end
  endtask

  task automatic exp_b_frame(input logic [63:0] stream, input logic prev);
    logic lr, b;
    for (int p = 0; p < 64; p++) begin
      lr = (p == 0);
      b  = (p == 0) ? prev : stream[64-p];
      bit_b_q.push_back({lr, b});
    end
  endtask

  task automatic push_a(input logic [31:0] d);
    @(posedge clk); #1 valid_a = 1'b1; data_a = d;
    @(posedge clk); #1 valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [63:0] d);
    @(posedge clk); #1 valid_b = 1'b1; data_b = d;
    @(posedge clk); #1 valid_b = 1'b0;
  endtask

  task automatic wait_fs(input bit sel_b);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel_b ? fs_b : fs_a) && n < 600);
    if (!(sel_b ? fs_b : fs_a)) begin
      checks++;
      errors++;
      $display("FAIL wait_frame_start: no pulse within %0d cycles (dut %0d)", n, sel_b);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor for the I2S instance
  always @(negedge clk) begin
    if (mon_a_on && sclk_a && !sclk_a_d) begin
      if (bit_a_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_bit: unexpected sclk rise lr=%0b sda=%0b at cycle %0d", lr_a, sda_a, cyc);
      end else begin
        e_a = bit_a_q.pop_front();
        check("a_bit", 64'({lr_a, sda_a}), 64'(e_a));
      end
    end
    if (fs_a) begin
      if (fs_a_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_frame_start: unexpected pulse at cycle %0d", cyc);
      end else begin
        f_a = fs_a_q.pop_front();
        check("a_underrun", 64'(ur_a), 64'(f_a[0]));
        if (f_a[1]) check("a_frame_gap", 64'(cyc - last_fs_a), 64'd256);
      end
      last_fs_a = cyc;
    end else if (ur_a) begin
      check("a_underrun_without_frame_start", 64'(ur_a), 64'd0);
    end
    sclk_a_d <= sclk_a;
  end

  // monitor for the TDM instance
  always @(negedge clk) begin
    if (sclk_b && !sclk_b_d) begin
      if (bit_b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_bit: unexpected sclk rise lr=%0b sda=%0b at cycle %0d", lr_b, sda_b, cyc);
      end else begin
        e_b = bit_b_q.pop_front();
        check("b_bit", 64'({lr_b, sda_b}), 64'(e_b));
      end
    end
    if (fs_b) begin
      if (fs_b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_frame_start: unexpected pulse at cycle %0d", cyc);
      end else begin
        f_b = fs_b_q.pop_front();
        check("b_underrun", 64'(ur_b), 64'(f_b[0]));
        if (f_b[1]) check("b_frame_gap", 64'(cyc - last_fs_b), 64'd512);
      end
      last_fs_b = cyc;
    end
    sclk_b_d <= sclk_b;
  end

  initial begin
    int n;
    rst = 1'b1; en_a = 1'b0; valid_a = 1'b0; data_a = 32'd0;
    en_b = 1'b0; valid_b = 1'b0; data_b = 64'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_sclk", 64'(sclk_a), 64'd0);
    check("reset_lrclk", 64'(lr_a), 64'd0);
    check("reset_sda", 64'(sda_a), 64'd0);
    check("reset_ready", 64'(ready_a), 64'd1);
    check("reset_level", 64'(lvl_a), 64'd0);
    check("reset_frame_start", 64'(fs_a), 64'd0);

    // I2S frame, two underrun frames, a second data frame, then stop in period ~10
    mon_a_on = 1'b1;
    push_a({16'h0F0F, 16'hA5C3});
    check("push_level", 64'(lvl_a), 64'd1);
    exp_a_frame(32'hA5C3_0F0F, 1'b0);
    exp_a_frame(32'h0000_0000, 1'b1);
    exp_a_frame(32'h0000_0000, 1'b0);
    fs_a_q.push_back(2'b00);
    fs_a_q.push_back(2'b11);
    fs_a_q.push_back(2'b11);
    @(posedge clk); #1 en_a = 1'b1;
    wait_fs(1'b0);
    wait_fs(1'b0);
    wait_fs(1'b0);
    check("underrun_sda_low", 64'(sda_a), 64'd0);
    push_a({16'h8001, 16'h1234});
    exp_a_frame(32'h1234_8001, 1'b0);
    bit_a_q.push_back(2'b01);
    fs_a_q.push_back(2'b10);
    wait_fs(1'b0);
    check("frame4_popped_level", 64'(lvl_a), 64'd0);
    push_a({16'h5555, 16'hAAAA});
    repeat (78) @(negedge clk);
    @(posedge clk); #1 en_a = 1'b0;
    repeat (300) @(negedge clk);
    check("stop_level_kept", 64'(lvl_a), 64'd1);
    check("stop_idle_sclk", 64'(sclk_a), 64'd0);
    check("stop_all_bits_seen", 64'(bit_a_q.size()), 64'd0);
    mon_a_on = 1'b0;

    // reset in the right-channel half of a running frame
    push_a({16'h2222, 16'h1111});
    check("pre_run_level", 64'(lvl_a), 64'd2);
    fs_a_q.push_back(2'b00);
    @(posedge clk); #1 en_a = 1'b1;
    wait_fs(1'b0);
    check("pop_on_start_level", 64'(lvl_a), 64'd1);
    repeat (150) @(negedge clk);
    n = 0;
    while (!sclk_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_lrclk_high", 64'(lr_a), 64'd1);
    #1 rst = 1'b1; en_a = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_sclk", 64'(sclk_a), 64'd0);
    check("midreset_lrclk", 64'(lr_a), 64'd0);
    check("midreset_sda", 64'(sda_a), 64'd0);
    check("midreset_ready", 64'(ready_a), 64'd1);
    check("midreset_level", 64'(lvl_a), 64'd0);

    // backpressure: fifth push is refused, first pop visible one cycle after enable
    for (int i = 0; i < 5; i++) begin
      push_a({16'hB000 + 16'(i), 16'hC000 + 16'(i)});
      check("bp_level", 64'(lvl_a), (i < 4) ? 64'(i + 1) : 64'd4);
      if (i >= 3) check("bp_ready_low", 64'(ready_a), 64'd0);
    end
    fs_a_q.push_back(2'b00);
    @(posedge clk); #1 en_a = 1'b1;
    @(posedge clk); #1 en_a = 1'b0;
    @(negedge clk);
    check("bp_pop_level", 64'(lvl_a), 64'd3);
    check("bp_pop_ready", 64'(ready_a), 64'd1);
    check("bp_frame_start", 64'(fs_a), 64'd1);
    repeat (300) @(negedge clk);
    check("bp_stop_level_kept", 64'(lvl_a), 64'd3);

    // TDM: slot 2 = 8001, two frames then stop
    push_b(64'h0000_8001_0000_0000);
    check("b_push_level", 64'(lvl_b), 64'd1);
    exp_b_frame(64'h0000_0000_8001_0000, 1'b0);
    exp_b_frame(64'h0000_0000_0000_0000, 1'b0);
    bit_b_q.push_back(2'b10);
    fs_b_q.push_back(2'b00);
    fs_b_q.push_back(2'b11);
    @(posedge clk); #1 en_b = 1'b1;
    wait_fs(1'b1);
    wait_fs(1'b1);
    @(posedge clk); #1 en_b = 1'b0;
    repeat (600) @(negedge clk);
    check("b_all_bits_seen", 64'(bit_b_q.size()), 64'd0);
    check("b_all_frames_seen", 64'(fs_b_q.size()), 64'd0);
    check("a_all_frames_seen", 64'(fs_a_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
